// File: rtl/serial_pattern_source_if.sv
// Load handshake and serial output bundle for serial_pattern_source.
// Handshake: a word transfers on a rising clk edge where load_valid and
// load_ready are both high and abort is low; data_in is sampled only on
// that edge. load_valid may be held high while load_ready is low; such
// cycles are ignored and do not need to be retracted.
interface serial_pattern_source_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             load_valid;
  logic             load_ready;
  logic             abort;
  logic             ser_out;
  logic             bit_strobe;
  logic             busy;
  logic             done;
  logic [1:0]       state_dbg;

  modport master (
    output data_in, load_valid, abort,
    input  load_ready, ser_out, bit_strobe, busy, done, state_dbg
  );

  modport slave (
    input  data_in, load_valid, abort,
    output load_ready, ser_out, bit_strobe, busy, done, state_dbg
  );
endinterface

// File: rtl/serial_pattern_source.sv
// Parallel-to-serial bit source: takes a WIDTH-bit word over a valid/ready
// handshake and shifts it out one bit every DIV clocks, with a strobe at the
// start of each bit period and a single-cycle done pulse after the last bit.
module serial_pattern_source #(
  parameter int WIDTH     = 8,
  parameter int DIV       = 1,
  parameter int MSB_FIRST = 1
) (
  input logic                    clk,
  input logic                    reset,
  serial_pattern_source_if.slave bus
);

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BIT_W = $clog2(WIDTH + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [DIV_W-1:0] div_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic             ser_q;
  logic             strobe_q;
  logic             busy_q;
  logic             done_q;

  logic             accept;
  logic             load_bit;
  logic [WIDTH-1:0] load_rest;
  logic             next_bit;
  logic [WIDTH-1:0] next_rest;

  assign accept = (state == IDLE) && bus.load_valid && !bus.abort;

  // The first bit goes straight to ser_out on accept; the shift register
  // holds only the bits still to come, so the next bit is always at the
  // same end of shreg.
  assign load_bit  = (MSB_FIRST != 0) ? bus.data_in[WIDTH-1] : bus.data_in[0];
  assign load_rest = (MSB_FIRST != 0) ? {bus.data_in[WIDTH-2:0], 1'b0}
                                      : {1'b0, bus.data_in[WIDTH-1:1]};
  assign next_bit  = (MSB_FIRST != 0) ? shreg[WIDTH-1] : shreg[0];
  assign next_rest = (MSB_FIRST != 0) ? {shreg[WIDTH-2:0], 1'b0}
                                      : {1'b0, shreg[WIDTH-1:1]};

  // Control FSM with registered serial outputs and bit/period counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      shreg    <= '0;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      ser_q    <= 1'b0;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (accept) begin
            state    <= SHIFT;
            shreg    <= load_rest;
            ser_q    <= load_bit;
            strobe_q <= 1'b1;
            busy_q   <= 1'b1;
            div_cnt  <= '0;
            bit_cnt  <= '0;
          end else begin
            ser_q    <= 1'b0;
            strobe_q <= 1'b0;
            busy_q   <= 1'b0;
          end
        end

        SHIFT: begin
          if (bus.abort) begin
            state    <= IDLE;
            ser_q    <= 1'b0;
            strobe_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            div_cnt  <= '0;
            bit_cnt  <= '0;
          end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == BIT_LAST) begin
              // Last bit period over: bit_cnt parks at WIDTH until the
              // return to IDLE clears it.
              state    <= DONE;
              done_q   <= 1'b1;
              ser_q    <= 1'b0;
              strobe_q <= 1'b0;
            end else begin
              shreg    <= next_rest;
              ser_q    <= next_bit;
              strobe_q <= 1'b1;
            end
          end else begin
            div_cnt  <= div_cnt + 1'b1;
            strobe_q <= 1'b0;
          end
        end

        DONE: begin
          // Abort here lands in the same place as normal completion.
          state    <= IDLE;
          done_q   <= 1'b0;
          busy_q   <= 1'b0;
          ser_q    <= 1'b0;
          strobe_q <= 1'b0;
          div_cnt  <= '0;
          bit_cnt  <= '0;
        end

        default: begin
          state    <= IDLE;
          done_q   <= 1'b0;
          busy_q   <= 1'b0;
          ser_q    <= 1'b0;
          strobe_q <= 1'b0;
          div_cnt  <= '0;
          bit_cnt  <= '0;
        end
      endcase
    end
  end

  assign bus.load_ready = (state == IDLE);
  assign bus.ser_out    = ser_q;
  assign bus.bit_strobe = strobe_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.state_dbg  = state;

endmodule

// File: tb/tb_serial_pattern_source.sv
// Bench for serial_pattern_source: three instances with different shapes
// (8b/DIV1/MSB, 8b/DIV3/LSB, 2b/DIV256/MSB) share clock and reset. A
// per-instance queue holds the expected per-clock output timeline derived
// from the word, bit order and bit period.
module tb_serial_pattern_source;

  logic clk;
  logic reset;

  logic        dv [3];
  logic [31:0] dd [3];
  logic        da [3];
  logic [4:0]  obs [3];

  // exp entry: {busy, done, bit_strobe, ser_out}; empty queue means idle
  logic [3:0] exp_q [3][$];
  logic       idle_now [3];

  int n_cmp;
  int n_err;
  logic alt;

  serial_pattern_source_if #(.WIDTH(8)) bus_a ();
  serial_pattern_source_if #(.WIDTH(8)) bus_b ();
  serial_pattern_source_if #(.WIDTH(2)) bus_c ();

  serial_pattern_source #(.WIDTH(8), .DIV(1), .MSB_FIRST(1)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a));
  serial_pattern_source #(.WIDTH(8), .DIV(3), .MSB_FIRST(0)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b));
  serial_pattern_source #(.WIDTH(2), .DIV(256), .MSB_FIRST(1)) dut_c (
    .clk(clk), .reset(reset), .bus(bus_c));

  assign bus_a.data_in    = dd[0][7:0];
  assign bus_a.load_valid = dv[0];
  assign bus_a.abort      = da[0];
  assign bus_b.data_in    = dd[1][7:0];
  assign bus_b.load_valid = dv[1];
  assign bus_b.abort      = da[1];
  assign bus_c.data_in    = dd[2][1:0];
  assign bus_c.load_valid = dv[2];
  assign bus_c.abort      = da[2];

  assign obs[0] = {bus_a.load_ready, bus_a.busy, bus_a.done, bus_a.bit_strobe, bus_a.ser_out};
  assign obs[1] = {bus_b.load_ready, bus_b.busy, bus_b.done, bus_b.bit_strobe, bus_b.ser_out};
  assign obs[2] = {bus_c.load_ready, bus_c.busy, bus_c.done, bus_c.bit_strobe, bus_c.ser_out};

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int p_width(input int i);
    return (i == 2) ? 2 : 8;
  endfunction

  function automatic int p_div(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 3 : 256);
  endfunction

  function automatic bit p_msb(input int i);
    return (i != 1);
  endfunction

  function automatic string p_name(input int i);
    return (i == 0) ? "a" : ((i == 1) ? "b" : "c");
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s at %0t: got %h want %h", tag, $time, got, want);
    end
  endtask

  // Expected timeline for one accepted word: WIDTH bit periods of DIV clocks,
  // strobe on the first clock of each, then one done clock.
  task automatic push_word(input int i, input logic [31:0] data);
    int w;
    int d;
    logic b;
    w = p_width(i);
    d = p_div(i);
    for (int j = 0; j < w; j++) begin
      b = p_msb(i) ? data[w-1-j] : data[j];
      for (int t = 0; t < d; t++)
        exp_q[i].push_back({1'b1, 1'b0, (t == 0), b});
    end
    exp_q[i].push_back(4'b1100);
  endtask

  // Apply the current inputs to the model for the coming edge, then check
  // the outputs of the following clock at the falling edge.
  task automatic step();
    logic [4:0] want;
    for (int i = 0; i < 3; i++) begin
      if (idle_now[i] && dv[i] && !da[i])
        push_word(i, dd[i]);
      else if (!idle_now[i] && da[i])
        exp_q[i].delete();
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      if (exp_q[i].size() == 0) begin
        want        = 5'b10000;
        idle_now[i] = 1'b1;
      end else begin
        want        = {1'b0, exp_q[i].pop_front()};
        idle_now[i] = 1'b0;
      end
      check({p_name(i), "_cycle"}, {27'd0, obs[i]}, {27'd0, want});
    end
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < 3; i++) begin
      dv[i] = 1'b0;
      da[i] = 1'b0;
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 3; i++) begin
      exp_q[i].delete();
      idle_now[i] = 1'b1;
    end
  endtask

  // Async reset in the middle of a clock period; outputs must drop at once.
  task automatic reset_pulse();
    #2;
    reset = 1'b0;
    #1;
    for (int i = 0; i < 3; i++)
      check({p_name(i), "_async_rst"}, {28'd0, obs[i][3:0]}, 32'd0);
    clear_inputs();
    clear_model();
    @(posedge clk);
    #2;
    reset = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    alt   = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) dd[i] = '0;
    clear_inputs();
    clear_model();
    #1;
    for (int i = 0; i < 3; i++)
      check({p_name(i), "_rst_state"}, {28'd0, obs[i][3:0]}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    step();

    // known words: 8'b1001_1000 MSB first, 8'h01 LSB first at DIV 3, 2'b10 at DIV 256
    dd[0] = 32'h98;
    dd[1] = 32'h01;
    dd[2] = 32'h2;
    for (int i = 0; i < 3; i++) dv[i] = 1'b1;
    step();
    clear_inputs();
    for (int i = 0; i < 3; i++) dd[i] = $urandom;
    repeat (520) step();

    // abort during the fourth bit period of a DIV=1 word
    dv[0] = 1'b1;
    dd[0] = $urandom;
    step();
    dv[0] = 1'b0;
    repeat (3) step();
    da[0] = 1'b1;
    step();
    da[0] = 1'b0;
    step();

    // abort together with load_valid while idle must not accept
    for (int i = 0; i < 3; i++) begin
      dv[i] = 1'b1;
      da[i] = 1'b1;
      dd[i] = $urandom;
    end
    step();
    clear_inputs();
    repeat (2) step();

    // async reset mid-word
    for (int i = 0; i < 3; i++) begin
      dv[i] = 1'b1;
      dd[i] = $urandom;
    end
    step();
    clear_inputs();
    repeat (5) step();
    reset_pulse();
    repeat (3) step();

    // load_valid held high with alternating data
    repeat (1200) begin
      alt = ~alt;
      for (int i = 0; i < 3; i++) begin
        dv[i] = 1'b1;
        da[i] = 1'b0;
        dd[i] = alt ? 32'hAAAA_AAAA : 32'h5555_5555;
      end
      step();
    end

    // random traffic with occasional aborts
    repeat (4000) begin
      for (int i = 0; i < 3; i++) begin
        dv[i] = ($urandom_range(0, 3) != 0);
        dd[i] = $urandom;
      end
      da[0] = ($urandom_range(0, 30) == 0);
      da[1] = ($urandom_range(0, 60) == 0);
      da[2] = ($urandom_range(0, 3000) == 0);
      step();
    end

    clear_inputs();
    repeat (520) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
